// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low key matrix one column at a time, debounces the
// per-scan result and reports one key code with a single-cycle valid strobe
// per accepted press.
//
// Ports:
//   system_clk  in   1  system clock
//   rst         in   1  asynchronous active-high reset
//   key_row     in   4  matrix rows, active-low, asynchronous to system_clk
//   key_col     out  4  column drive, active-low one-hot
//   key_code    out  4  last accepted key, row_idx*4 + col_idx
//   key_valid   out  1  one-cycle strobe when key_code is (re)issued
//   key_down    out  1  high while the accepted key is held
//
// Optional feature macro: KEYPAD_REPEAT_EN
//   When defined, a held key re-strobes key_valid after REPEAT_DELAY_SCANS
//   held scans and then every REPEAT_RATE_SCANS held scans.
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV           = 1000,
    parameter int DEBOUNCE_SCANS     = 4,
    parameter int REPEAT_DELAY_SCANS = 64,
    parameter int REPEAT_RATE_SCANS  = 16
) (
    input  logic       system_clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Scan and accumulation state
    // -----------------------------------------------------------------------
    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic             hit_reg;
    logic [3:0]       cand_reg;

    // -----------------------------------------------------------------------
    // Debounce FSM state
    // -----------------------------------------------------------------------
    state_t           state;
    logic [3:0]       latched;
    logic [DB_W-1:0]  db_cnt;

    logic [3:0]       row_low;
    logic [1:0]       col_row;
    logic             col_hit;
    logic             sample_now;
    logic             scan_end;
    logic             scan_hit;
    logic [3:0]       scan_cand;
    logic [DB_W-1:0]  db_inc;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row_low
            assign row_low[gi] = ~row_sync[gi];
        end
    endgenerate

    // Lowest pressed row index within the currently sampled column.
    always_comb begin
        col_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (row_low[r]) begin
                col_row = 2'(r);
            end
        end
    end

    assign col_hit    = |row_low;
    assign sample_now = (div_cnt == DIV_LAST);
    assign scan_end   = sample_now && (col_idx == 2'd3);

    // Fold the col3 sample into the scan result so the FSM sees the whole
    // scan on the very edge that ends it.
    assign scan_hit  = hit_reg | col_hit;
    assign scan_cand = hit_reg ? cand_reg : {col_row, col_idx};

    // Saturating increment; the FSM leaves the counting state on reaching
    // the target, so saturation is only a guard.
    assign db_inc = (db_cnt == DB_TARGET) ? db_cnt : db_cnt + DB_W'(1);

    // -----------------------------------------------------------------------
    // Synchroniser, column dwell/rotation and per-scan accumulation
    // -----------------------------------------------------------------------
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
            div_cnt  <= '0;
            col_idx  <= 2'd0;
            key_col  <= 4'b1110;
            hit_reg  <= 1'b0;
            cand_reg <= 4'd0;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
            if (sample_now) begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                key_col <= {key_col[2:0], key_col[3]};
                if (col_idx == 2'd3) begin
                    hit_reg  <= 1'b0;
                    cand_reg <= 4'd0;
                end else if (!hit_reg && col_hit) begin
                    // First hit in scan order wins; later hits are ignored.
                    hit_reg  <= 1'b1;
                    cand_reg <= {col_row, col_idx};
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                             REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    // rep_cnt counts held scans toward the first repeat; once rep_armed is
    // set it restarts and counts toward each subsequent repeat.
    logic [REP_W-1:0] rep_cnt;
    logic             rep_armed;
    logic [REP_W-1:0] rep_inc;
    logic [REP_W-1:0] rep_goal;

    assign rep_inc  = rep_cnt + REP_W'(1);
    assign rep_goal = rep_armed ? REP_W'(REPEAT_RATE_SCANS)
                                : REP_W'(REPEAT_DELAY_SCANS);
`else
    // Repeat timing is only meaningful with the repeat feature built in.
    if (REPEAT_DELAY_SCANS < 0 || REPEAT_RATE_SCANS < 0) begin : g_repeat_unused
    end
`endif

    // -----------------------------------------------------------------------
    // Debounce FSM with registered outputs; advances only at scan end.
    // -----------------------------------------------------------------------
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            latched   <= 4'd0;
            db_cnt    <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (scan_end) begin
                case (state)
                    IDLE: begin
                        if (scan_hit) begin
                            state   <= DEBOUNCE;
                            latched <= scan_cand;
                            db_cnt  <= DB_W'(1);
                        end
                    end
                    DEBOUNCE: begin
                        if (scan_hit && (scan_cand == latched)) begin
                            if (db_inc == DB_TARGET) begin
                                state     <= HELD;
                                key_code  <= latched;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                db_cnt    <= '0;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt   <= '0;
                                rep_armed <= 1'b0;
`endif
                            end else begin
                                db_cnt <= db_inc;
                            end
                        end else begin
                            // A gap or a different key restarts debouncing.
                            state  <= IDLE;
                            db_cnt <= '0;
                        end
                    end
                    HELD: begin
                        if (!scan_hit) begin
                            state  <= RELEASE;
                            db_cnt <= DB_W'(1);
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt   <= '0;
                            rep_armed <= 1'b0;
                        end else begin
                            if (rep_inc == rep_goal) begin
                                key_valid <= 1'b1;
                                rep_cnt   <= '0;
                                rep_armed <= 1'b1;
                            end else begin
                                rep_cnt <= rep_inc;
                            end
`endif
                        end
                    end
                    RELEASE: begin
                        if (scan_hit) begin
                            // Release bounce: back to HELD without a strobe.
                            state  <= HELD;
                            db_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt   <= '0;
                            rep_armed <= 1'b0;
`endif
                        end else if (db_inc == DB_TARGET) begin
                            state    <= IDLE;
                            key_down <= 1'b0;
                            db_cnt   <= '0;
                        end else begin
                            db_cnt <= db_inc;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//
// Drives keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3, scan = 16 cycles)
// with a modelled key matrix whose rows respond to the driven column.
// The set of pressed keys changes only at scan boundaries; a scan-level
// reference model predicts strobe, key_down and key_code after each scan.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int RD = 4;
    localparam int RR = 2;
    localparam int SCAN_CYCLES = 4 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] pressed = 16'h0000;

    int n_checks = 0;
    int n_errors = 0;
    int scan_no  = 0;

    // Reference model state (scan granularity)
    bit m_down  = 1'b0;
    int m_run   = 0;
    int m_key   = 0;
    int m_code  = 0;
    int m_quiet = 0;
    int m_held  = 0;

    keypad_scanner #(
        .SCAN_DIV          (SD),
        .DEBOUNCE_SCANS    (DB),
        .REPEAT_DELAY_SCANS(RD),
        .REPEAT_RATE_SCANS (RR)
    ) dut (
        .system_clk(clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key at (r,c) pulls row r low while column c is
    // driven low.
    always_comb begin
        logic [3:0] sel;
        key_row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            sel = 4'hF ^ (4'h1 << c);
            if (key_col == sel) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[r*4+c]) key_row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s scan=%0d got=%0d expected=%0d", tag, scan_no, got, exp);
        end
    endtask

    task automatic model_reset();
        m_down  = 1'b0;
        m_run   = 0;
        m_key   = 0;
        m_code  = 0;
        m_quiet = 0;
        m_held  = 0;
    endtask

    // One full scan of the matrix holding mask m; returns whether a
    // key_valid strobe is expected right after its end.
    task automatic model_scan(input logic [15:0] m, output bit strobe);
        bit hit;
        bit found;
        int cand;
        hit    = (m != 16'h0);
        found  = 1'b0;
        cand   = 0;
        strobe = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!found && m[r*4+c]) begin
                    cand  = r * 4 + c;
                    found = 1'b1;
                end
            end
        end
        if (!m_down) begin
            if (!hit)              m_run = 0;
            else if (m_run == 0)   begin m_key = cand; m_run = 1; end
            else if (cand == m_key) m_run++;
            else                   m_run = 0;
            if (m_run == DB) begin
                strobe  = 1'b1;
                m_code  = m_key;
                m_down  = 1'b1;
                m_run   = 0;
                m_quiet = 0;
                m_held  = 0;
            end
        end else begin
            if (hit) begin
                if (m_quiet > 0) begin
                    m_quiet = 0;
                    m_held  = 0;
                end else begin
                    m_held++;
`ifdef KEYPAD_REPEAT_EN
                    if (m_held == RD || (m_held > RD && ((m_held - RD) % RR) == 0))
                        strobe = 1'b1;
`endif
                end
            end else begin
                m_quiet++;
                m_held = 0;
                if (m_quiet == DB) begin
                    m_down  = 1'b0;
                    m_quiet = 0;
                end
            end
        end
    endtask

    task automatic run_scan(input logic [15:0] m);
        bit         es;
        logic [3:0] exp_col;
        scan_no++;
        pressed = m;
        model_scan(m, es);
        for (int k = 1; k <= SCAN_CYCLES; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_col = 4'hF ^ (4'h1 << ((k / SD) % 4));
            check("key_col", int'(key_col), int'(exp_col));
            if (k < SCAN_CYCLES) check("valid_mid_scan", int'(key_valid), 0);
        end
        check("key_valid", int'(key_valid), int'(es));
        check("key_down", int'(key_down), int'(m_down));
        check("key_code", int'(key_code), m_code);
        $display("scan %0d mask=%04h valid=%0b down=%0b code=%0d (exp %0b/%0b/%0d)",
                 scan_no, m, key_valid, key_down, key_code, es, m_down, m_code);
    endtask

    task automatic run_scans(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) run_scan(m);
    endtask

    // Reset asserted mid-cycle: outputs must clear without waiting for a
    // clock edge. Released just after a rising edge so the next edge is the
    // first counted cycle.
    task automatic reset_midop();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_key_col", int'(key_col), 4'b1110);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_down", int'(key_down), 0);
        check("rst_key_code", int'(key_code), 0);
        $display("reset asserted mid-cycle col=%04b valid=%0b down=%0b code=%0d",
                 key_col, key_valid, key_down, key_code);
        pressed = 16'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] m;
        int          r;
        int          len;

        // Power-on reset
        rst = 1'b1;
        pressed = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("por_key_col", int'(key_col), 4'b1110);
        check("por_key_valid", int'(key_valid), 0);
        check("por_key_down", int'(key_down), 0);
        check("por_key_code", int'(key_code), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        run_scans(16'h0, 2);

        // Clean press of key 6 (row1/col2), held 10 scans, then release.
        run_scans(16'h1 << 6, 10);
        run_scans(16'h0, 4);

        // Bounce reject on key 0, then a clean 3-scan press.
        run_scans(16'h1, 2);
        run_scans(16'h0, 1);
        run_scans(16'h1, 3);

        // Release bounce: absent 2 scans then present again.
        run_scans(16'h0, 2);
        run_scans(16'h1, 3);
        run_scans(16'h0, 4);

        // Two keys together: key 13 (row3/col1) wins over key 3 (row0/col3).
        run_scans((16'h1 << 13) | (16'h1 << 3), 5);

        // Reset while key 13 is held, then check the column walk restarts.
        reset_midop();
        run_scans(16'h0, 2);
        run_scans(16'h1 << 9, 4);
        run_scans(16'h0, 4);

        // Randomised press patterns.
        for (int t = 0; t < 60; t++) begin
            r = int'($urandom_range(0, 99));
            if (r < 35)      m = 16'h0;
            else if (r < 80) m = 16'h1 << $urandom_range(0, 15);
            else             m = (16'h1 << $urandom_range(0, 15)) |
                                 (16'h1 << $urandom_range(0, 15));
            len = int'($urandom_range(1, 5));
            run_scans(m, len);
        end
        run_scans(16'h0, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the LED matrix driver: drives a 4x4 key matrix one column at a time and reads the rows back.
- Debounces the scanned result and presents one key code plus a single-cycle valid strobe per press.
- Sits beside the display path in the game top, on the same system_clk and rst, feeding player input to the map/game logic.

Parameters:
SCAN_DIV, 1000, system_clk cycles each column is driven (minimum 4)
DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press or a release (minimum 2)
REPEAT_DELAY_SCANS, 64, scans held before first auto-repeat (used only with KEYPAD_REPEAT_EN)
REPEAT_RATE_SCANS, 16, scans between auto-repeats (used only with KEYPAD_REPEAT_EN)

Ports:
system_clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
key_row  input  4  matrix rows, active-low (pulled up externally), asynchronous to system_clk
key_col  output  4  column drive, active-low one-hot
key_code  output  4  last accepted key: row_idx*4 + col_idx
key_valid  output  1  one-cycle strobe when key_code is newly accepted
key_down  output  1  high while the accepted key is held (until release is debounced)

Behaviour:
- Reset (async, while rst=1): key_col=4'b1110, key_code=0, key_valid=0, key_down=0, FSM=IDLE, all counters=0, synchroniser flops=4'b1111.
- key_row passes through a 2-flop synchroniser before any use.
- Dwell counter div_cnt runs 0..SCAN_DIV-1. When div_cnt==SCAN_DIV-1:
  - sample the synchronised rows for the current column;
  - rotate key_col to the next column on the following cycle (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - One full scan = 4*SCAN_DIV cycles.
- Per-scan accumulation:
  - hit = any row low in any column during the scan.
  - cand = first pressed position in scan order: col0..col3, and within a column the lowest row index.
  - Multiple simultaneous keys resolve to cand; the others are ignored.
- Scan end = the sample of col3. The FSM advances only at scan end; hit and cand clear for the next scan.
- FSM:
  - IDLE: hit -> DEBOUNCE; latch cand; db_cnt=1.
  - DEBOUNCE: hit and cand==latched -> db_cnt+1. When db_cnt reaches DEBOUNCE_SCANS -> HELD; key_code<=latched; key_valid=1 for exactly one cycle; key_down=1. No hit, or a different cand -> IDLE with db_cnt=0, no strobe.
  - HELD: no hit -> RELEASE with db_cnt=1. Any hit (even a different key) -> stay HELD.
  - RELEASE: no hit -> db_cnt+1. When db_cnt reaches DEBOUNCE_SCANS -> IDLE and key_down=0. Hit -> HELD (bounce absorbed, no new strobe).
- Latency: key_valid and key_down rise the cycle after the scan end of the DEBOUNCE_SCANS-th consecutive matching scan. key_code updates in that same cycle and holds until the next accepted press.
- Counters: db_cnt width clog2(DEBOUNCE_SCANS+1), saturating, never wraps. div_cnt wraps to 0.
- Mid-scan press: a press starting partway through a scan is counted only if its column is sampled low in that scan; a partial first scan may or may not count.
- Reset mid-operation: immediate return to reset values, no strobe, scan restarts at col0.

Optional Feature:
- KEYPAD_REPEAT_EN defined:
  - In HELD, a scan counter rep_cnt counts consecutive held scans.
  - At REPEAT_DELAY_SCANS, then every REPEAT_RATE_SCANS after, key_valid pulses one cycle with key_code unchanged.
  - rep_cnt clears on entry to HELD and on HELD->RELEASE.
- Undefined: exactly one key_valid per press; rep_cnt and both REPEAT parameters are unused.

Test Plan:
- Settings SCAN_DIV=4, DEBOUNCE_SCANS=3 (scan = 16 cycles) for all tests; scan-end counts below start from the first scan end at which the key is sampled.
- Reset check: assert rst mid-cycle -> key_col=1110, key_valid=0, key_down=0, key_code=0 immediately. Release rst -> key_col walks 1101 at cycle 4, 1011 at cycle 8, 0111 at cycle 12, 1110 at cycle 16.
- Clean press: model row1 low whenever col2 is driven, held 10 scans -> one key_valid, key_code=6, key_down=1 the cycle after the 3rd scan end. Release -> key_down=0 the cycle after the 3rd empty scan end.
- Bounce reject: key row0/col0 present for 2 scans, absent for 1, present for 2 -> no key_valid. Held to 3 consecutive scans -> one strobe, key_code=0.
- Release bounce: while HELD, key absent for 2 scans then present -> key_down stays 1, no second key_valid.
- Two keys: row3/col1 and row0/col3 pressed together -> key_code=13 (col1 scanned first); only one strobe.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY_SCANS=4, REPEAT_RATE_SCANS=2, key 6 held 10 scans past acceptance -> strobes at acceptance, then at held scans 4, 6, 8, 10; key_code=6 throughout.
